// File: rtl/matrix_pkg.sv
// Shared definitions for the hit-count matrix accumulator and its readout.
package matrix_pkg;

  localparam int unsigned MA_SIZE = 4;
  localparam int unsigned CNT_W   = 9;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } readout_state_e;

  // Flattened position of cell (x, y); x is the major index.
  function automatic int unsigned cell_index(input int unsigned x, input int unsigned y);
    return x * MA_SIZE + y;
  endfunction

endpackage

// File: rtl/matrix_peak_tracker.sv
// Running maximum over a stream of cells; a tie keeps the earliest cell.
module matrix_peak_tracker #(
  parameter int unsigned CNT_W = 9,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             xfer,
  input  logic [CNT_W-1:0] value,
  input  logic [IDX_W-1:0] x,
  input  logic [IDX_W-1:0] y,
  // Running peak including the current beat if it transfers this cycle
  output logic [CNT_W-1:0] run_value,
  output logic [IDX_W-1:0] run_x,
  output logic [IDX_W-1:0] run_y
);

  logic [CNT_W-1:0] max_value_q;
  logic [IDX_W-1:0] max_x_q;
  logic [IDX_W-1:0] max_y_q;
  logic             beat_wins;

  // Strictly greater wins, so the first cell holding the maximum is kept.
  always_comb begin
    beat_wins = xfer && (value > max_value_q);
    run_value = max_value_q;
    run_x     = max_x_q;
    run_y     = max_y_q;
    if (clear) begin
      run_value = '0;
      run_x     = '0;
      run_y     = '0;
    end else if (beat_wins) begin
      run_value = value;
      run_x     = x;
      run_y     = y;
    end
  end

  // Hold the running peak between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_value_q <= '0;
      max_x_q     <= '0;
      max_y_q     <= '0;
    end else begin
      max_value_q <= run_value;
      max_x_q     <= run_x;
      max_y_q     <= run_y;
    end
  end

endmodule

// File: rtl/matrix_readout.sv
// Snapshots the counter matrix on start and streams each cell with its (x, y)
// over valid/ready, publishing the frame's peak cell when the frame ends.
module matrix_readout
  import matrix_pkg::*;
#(
  parameter int unsigned MA_SIZE = matrix_pkg::MA_SIZE,
  parameter int unsigned CNT_W   = matrix_pkg::CNT_W,
  parameter int unsigned IDX_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [MA_SIZE*MA_SIZE*CNT_W-1:0] matrix_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [CNT_W-1:0]           out_data,
  output logic [IDX_W-1:0]           out_x,
  output logic [IDX_W-1:0]           out_y,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           peak_value,
  output logic [IDX_W-1:0]           peak_x,
  output logic [IDX_W-1:0]           peak_y
);

  localparam int unsigned NumCells = MA_SIZE * MA_SIZE;
  localparam int unsigned CntIdxW  = (NumCells > 1) ? $clog2(NumCells) : 1;
  localparam logic [CntIdxW-1:0] LastIdx = CntIdxW'(NumCells - 1);
  localparam logic [CntIdxW-1:0] SizeIdx = CntIdxW'(MA_SIZE);

  readout_state_e   state_q;
  logic [CntIdxW-1:0] idx_q;
  logic [CNT_W-1:0] shadow_q [NumCells];
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] peak_value_q;
  logic [IDX_W-1:0] peak_x_q;
  logic [IDX_W-1:0] peak_y_q;

  logic             xfer;
  logic             clear;
  logic [CntIdxW-1:0] cell_x;
  logic [CntIdxW-1:0] cell_y;
  logic [CNT_W-1:0] run_value;
  logic [IDX_W-1:0] run_x;
  logic [IDX_W-1:0] run_y;

  // Decode the current cell; beat fields read as zero whenever no beat is offered.
  always_comb begin
    xfer      = valid_q & out_ready;
    clear     = (state_q == IDLE) & start;
    cell_x    = idx_q / SizeIdx;
    cell_y    = idx_q % SizeIdx;
    out_valid = valid_q;
    out_last  = last_q;
    busy      = busy_q;
    done      = done_q;
    out_data  = '0;
    out_x     = '0;
    out_y     = '0;
    if (valid_q) begin
      out_data = shadow_q[idx_q];
      out_x    = IDX_W'(cell_x);
      out_y    = IDX_W'(cell_y);
    end
    peak_value = peak_value_q;
    peak_x     = peak_x_q;
    peak_y     = peak_y_q;
  end

  matrix_peak_tracker #(
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_peak (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .xfer      (xfer),
    .value     (out_data),
    .x         (out_x),
    .y         (out_y),
    .run_value (run_value),
    .run_x     (run_x),
    .run_y     (run_y)
  );

  // Readout FSM: snapshot on start, step the index per transfer, one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      peak_value_q <= '0;
      peak_x_q     <= '0;
      peak_y_q     <= '0;
      for (int k = 0; k < NumCells; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NumCells; k++) begin
              shadow_q[k] <= matrix_in[k*CNT_W +: CNT_W];
            end
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= (LastIdx == '0);
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_q) begin
              // Final beat accepted: publish the peak, including this beat.
              idx_q        <= '0;
              valid_q      <= 1'b0;
              last_q       <= 1'b0;
              done_q       <= 1'b1;
              peak_value_q <= run_value;
              peak_x_q     <= run_x;
              peak_y_q     <= run_y;
              state_q      <= DONE;
            end else begin
              idx_q  <= idx_q + CntIdxW'(1);
              last_q <= ((idx_q + CntIdxW'(1)) == LastIdx);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          idx_q   <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_readout.sv
// Randomized bench for matrix_readout against a frame-level reference model.
module tb_matrix_readout;

  localparam int MS = 4;
  localparam int CW = 9;
  localparam int IW = 6;
  localparam int NC = MS * MS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NC*CW-1:0] matrix_in;
  logic             out_ready;
  logic             out_valid;
  logic [CW-1:0]    out_data;
  logic [IW-1:0]    out_x;
  logic [IW-1:0]    out_y;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [CW-1:0]    peak_value;
  logic [IW-1:0]    peak_x;
  logic [IW-1:0]    peak_y;

  int total = 0;
  int bad   = 0;
  int cells [NC];
  int exp_pv = 0;
  int exp_px = 0;
  int exp_py = 0;

  always #5 clk = ~clk;

  matrix_readout #(
    .MA_SIZE (MS),
    .CNT_W   (CW),
    .IDX_W   (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .matrix_in  (matrix_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .peak_value (peak_value),
    .peak_x     (peak_x),
    .peak_y     (peak_y)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_matrix();
    for (int k = 0; k < NC; k++) matrix_in[k*CW +: CW] = CW'(cells[k]);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_pv"}, 32'(peak_value), exp_pv);
    check_eq({tag, "_px"}, 32'(peak_x), exp_px);
    check_eq({tag, "_py"}, 32'(peak_y), exp_py);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // abort_at >= 0 pulls reset once that many beats have transferred.
  task automatic run_frame(input int ready_mode, input bit poison, input bit extra,
                           input int abort_at);
    int  k;
    int  fv, fx, fy;
    bit  r;
    bit  mid_done;
    // Reference peak: first cell holding the largest value, default 0 at (0,0).
    fv = 0; fx = 0; fy = 0;
    for (int c = 0; c < NC; c++) begin
      if (cells[c] > fv) begin
        fv = cells[c]; fx = c / MS; fy = c % MS;
      end
    end
    @(negedge clk);
    load_matrix();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poison) matrix_in = '1;
    k = 0;
    mid_done = 1'b0;
    for (int cyc = 0; cyc < 400 && k < NC; cyc++) begin
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_data", 32'(out_data), 0);
        check_eq("rst_x", 32'(out_x), 0);
        check_eq("rst_y", 32'(out_y), 0);
        check_eq("rst_last", 32'(out_last), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_pv", 32'(peak_value), 0);
        exp_pv = 0; exp_px = 0; exp_py = 0;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_hold_done", 32'(done), 0);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_quiet("post_rst");
        end
        return;
      end
      check_eq("beat_valid", 32'(out_valid), 1);
      check_eq("beat_data", 32'(out_data), cells[k]);
      check_eq("beat_x", 32'(out_x), k / MS);
      check_eq("beat_y", 32'(out_y), k % MS);
      check_eq("beat_last", 32'(out_last), (k == NC - 1) ? 1 : 0);
      check_eq("beat_busy", 32'(busy), 1);
      check_eq("beat_done", 32'(done), 0);
      start = 1'b0;
      if (extra && k == 5 && !mid_done) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      case (ready_mode)
        0: r = 1'b1;
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (r) k++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    check_eq("beat_count", 32'(k), NC);
    exp_pv = fv; exp_px = fx; exp_py = fy;
    check_eq("end_done", 32'(done), 1);
    check_eq("end_valid", 32'(out_valid), 0);
    check_eq("end_busy", 32'(busy), 1);
    check_eq("end_pv", 32'(peak_value), exp_pv);
    check_eq("end_px", 32'(peak_x), exp_px);
    check_eq("end_py", 32'(peak_y), exp_py);
    start = extra;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      check_quiet("after");
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    matrix_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_quiet("idle");
    end

    // Ascending values at full rate, then under 1,0,0,1 backpressure.
    for (int k = 0; k < NC; k++) cells[k] = k + 1;
    run_frame(0, 1'b0, 1'b0, -1);
    run_frame(1, 1'b0, 1'b0, -1);

    // Input overwritten right after the snapshot.
    for (int k = 0; k < NC; k++) cells[k] = int'($urandom_range(0, 510));
    run_frame(0, 1'b1, 1'b0, -1);

    // Tied maxima with stray start pulses mid-frame and on DONE.
    for (int k = 0; k < NC; k++) cells[k] = 3;
    cells[5] = 200;
    cells[10] = 200;
    run_frame(2, 1'b0, 1'b1, -1);

    // Reset after seven beats, then a fresh frame starting from cell 0.
    for (int k = 0; k < NC; k++) cells[k] = int'($urandom_range(0, 511));
    run_frame(1, 1'b0, 1'b0, 7);
    for (int k = 0; k < NC; k++) cells[k] = 0;
    run_frame(0, 1'b0, 1'b0, -1);

    // Random frames; narrow value ranges make ties likely.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NC; k++) begin
        cells[k] = (f % 2 == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 4));
      end
      run_frame(2, f[0], f[1], -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
